// File: rtl/router_pkg.sv
// Shared definitions for the router host-side packet transmitter:
// header field layout, reserved address and transmit FSM states.
package router_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         MAX_LEN      = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_e;

    function automatic logic [7:0] make_hdr(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] h;
        h = '0;
        h[LEN_MSB:LEN_LSB]   = len;
        h[ADDR_MSB:ADDR_LSB] = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: one synchronous write port, one combinational read
// port. Contents are deliberately not reset.
module router_tx_buf #(
    parameter int Width = 8,
    parameter int Depth = 63
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] waddr,
    input  logic [Width-1:0]         wdata,
    input  logic [$clog2(Depth)-1:0] raddr,
    output logic [Width-1:0]         rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Host-side transmitter for the 1x3 router input port: buffers a whole payload,
// then sends header, payload and XOR parity while honouring busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int Width     = 8,
    parameter int MaxLen    = MAX_LEN,
    parameter int GapCycles = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_addr,
    input  logic [5:0]       cmd_len,
    input  logic             pl_valid,
    input  logic [Width-1:0] pl_data,
    output logic             pl_ready,
    input  logic             busy,
    output logic [Width-1:0] data_out,
    output logic             pkt_valid,
    output logic             cmd_err,
    output logic             pkt_done,
    output logic [15:0]      pkt_cnt
);

    localparam int AW = $clog2(MaxLen);
    localparam int GW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;

    tx_state_e        state_q, state_d;
    logic [1:0]       addr_q;
    logic [5:0]       len_q;
    logic [5:0]       idx_q;
    logic [Width-1:0] parity_q;
    logic [GW-1:0]    gap_q;
    logic [Width-1:0] buf_rd;

    logic cmd_accept, cmd_bad, pl_accept, last_load, more;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign pl_ready   = (state_q == ST_LOAD);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign cmd_bad    = (cmd_addr == ADDR_INVALID) || (cmd_len == 6'd0);
    assign pl_accept  = pl_valid && pl_ready;
    assign last_load  = pl_accept && (idx_q == len_q - 6'd1);
    // idx_q reaches len_q once every payload byte has been handed to the router
    assign more       = (idx_q != len_q);

    router_tx_buf #(
        .Width (Width),
        .Depth (MaxLen)
    ) u_buf (
        .clk   (clk),
        .we    (pl_accept),
        .waddr (idx_q[AW-1:0]),
        .wdata (pl_data),
        .raddr (idx_q[AW-1:0]),
        .rdata (buf_rd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (cmd_accept && !cmd_bad) state_d = ST_LOAD;
            ST_LOAD:    if (last_load) state_d = ST_HEADER;
            ST_HEADER,
            ST_PAYLOAD: if (!busy) state_d = more ? ST_PAYLOAD : ST_PARITY;
            ST_PARITY:  if (!busy) state_d = (GapCycles == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:     if (gap_q <= GW'(1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out  <= '0;
            pkt_valid <= 1'b0;
            cmd_err   <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_cnt   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            parity_q  <= '0;
            gap_q     <= '0;
        end else begin
            cmd_err  <= 1'b0;
            pkt_done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        if (cmd_bad) begin
                            cmd_err <= 1'b1;
                        end else begin
                            addr_q <= cmd_addr;
                            len_q  <= cmd_len;
                            idx_q  <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (last_load) begin
                        data_out  <= Width'(make_hdr(len_q, addr_q));
                        parity_q  <= Width'(make_hdr(len_q, addr_q));
                        pkt_valid <= 1'b1;
                        idx_q     <= '0;
                    end else if (pl_accept) begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                ST_HEADER, ST_PAYLOAD: begin
                    if (!busy) begin
                        if (more) begin
                            data_out <= buf_rd;
                            parity_q <= parity_q ^ buf_rd;
                            idx_q    <= idx_q + 6'd1;
                        end else begin
                            data_out  <= parity_q;
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        data_out <= '0;
                        pkt_done <= 1'b1;
                        pkt_cnt  <= pkt_cnt + 16'd1;
                        gap_q    <= GW'(GapCycles);
                    end
                end
                ST_GAP:  gap_q <= gap_q - GW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets checked every cycle against a
// queue-based packet model, plus hand-computed header/parity literals.
module tb_router_pkt_tx;

    localparam int GAP = 1;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        pl_valid;
    logic [7:0]  pl_data;
    logic        pl_ready;
    logic        busy;
    logic [7:0]  data_out;
    logic        pkt_valid;
    logic        cmd_err;
    logic        pkt_done;
    logic [15:0] pkt_cnt;

    router_pkt_tx #(
        .Width     (8),
        .MaxLen    (63),
        .GapCycles (GAP)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .cmd_err   (cmd_err),
        .pkt_done  (pkt_done),
        .pkt_cnt   (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: mode 0 idle, 1 collecting payload, 2 sending stream, 3 gap.
    int          m_mode, m_len, m_addr, m_ptr, m_gap;
    logic [7:0]  m_pl[$];
    logic [8:0]  m_st[$];
    logic [8:0]  m_cur;
    logic [7:0]  m_par, m_hdr;
    logic        m_err, m_done;
    logic [15:0] m_cnt;

    always @(negedge clk) begin
        if (!resetn) begin
            m_mode = 0; m_ptr = 0; m_gap = 0;
            m_err = 1'b0; m_done = 1'b0; m_cnt = '0;
            m_st.delete(); m_pl.delete();
            chk("rst_data_out", 32'(data_out), 32'h0);
            chk("rst_pkt_valid", 32'(pkt_valid), 32'h0);
            chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
        end else begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0));
            chk("pl_ready", 32'(pl_ready), 32'(m_mode == 1));
            if (m_mode == 2) begin
                m_cur = m_st[m_ptr];
                chk("data_out", 32'(data_out), 32'(m_cur[7:0]));
                chk("pkt_valid", 32'(pkt_valid), 32'(m_cur[8]));
            end else begin
                chk("data_out_idle", 32'(data_out), 32'h0);
                chk("pkt_valid_idle", 32'(pkt_valid), 32'h0);
            end
            chk("cmd_err", 32'(cmd_err), 32'(m_err));
            chk("pkt_done", 32'(pkt_done), 32'(m_done));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));

            // advance by what the coming edge will see on the inputs
            m_err = 1'b0;
            m_done = 1'b0;
            case (m_mode)
                0: if (cmd_valid) begin
                    if (cmd_addr == 2'd3 || cmd_len == 6'd0) m_err = 1'b1;
                    else begin
                        m_addr = int'(cmd_addr);
                        m_len  = int'(cmd_len);
                        m_pl.delete();
                        m_mode = 1;
                    end
                end
                1: if (pl_valid) begin
                    m_pl.push_back(pl_data);
                    if (m_pl.size() == m_len) begin
                        m_hdr = 8'(m_len * 4 + m_addr);
                        m_par = m_hdr;
                        m_st.delete();
                        m_st.push_back({1'b1, m_hdr});
                        foreach (m_pl[i]) begin
                            m_st.push_back({1'b1, m_pl[i]});
                            m_par = m_par ^ m_pl[i];
                        end
                        m_st.push_back({1'b0, m_par});
                        m_ptr = 0;
                        m_mode = 2;
                    end
                end
                2: if (!busy) begin
                    if (m_ptr == m_st.size() - 1) begin
                        m_done = 1'b1;
                        m_cnt++;
                        if (GAP > 0) begin m_mode = 3; m_gap = GAP; end
                        else m_mode = 0;
                    end else m_ptr++;
                end
                3: begin
                    m_gap--;
                    if (m_gap == 0) m_mode = 0;
                end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        pl_valid = 1'b1;
        pl_data  = b;
        tick();
        pl_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        chk(name, 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk("reset_cnt", 32'(pkt_cnt), 32'h0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
        tick();

        // basic packet, no back-pressure
        send_cmd(2'd1, 6'd3);
        push(8'hAA); push(8'hBB); push(8'hCC);
        chk("t1_hdr", 32'(data_out), 32'h0D);
        repeat (4) tick();
        chk("t1_parity", 32'(data_out), 32'hD0);
        chk("t1_parity_valid", 32'(pkt_valid), 32'h0);
        tick();
        chk("t1_done", 32'(pkt_done), 32'h1);
        chk("t1_cnt", 32'(pkt_cnt), 32'h1);
        wait_idle("t1_idle");

        // busy held for 3 cycles while BB is presented
        send_cmd(2'd1, 6'd3);
        push(8'hAA); push(8'hBB); push(8'hCC);
        tick(); tick();
        chk("t2_bb", 32'(data_out), 32'hBB);
        busy = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_bb_hold", 32'(data_out), 32'hBB);
            chk("t2_valid_hold", 32'(pkt_valid), 32'h1);
        end
        busy = 1'b0;
        tick();
        chk("t2_cc", 32'(data_out), 32'hCC);
        tick();
        chk("t2_parity", 32'(data_out), 32'hD0);
        wait_idle("t2_idle");
        chk("t2_cnt", 32'(pkt_cnt), 32'h2);

        // rejected commands
        send_cmd(2'd3, 6'd5);
        chk("t3_err_addr", 32'(cmd_err), 32'h1);
        send_cmd(2'd0, 6'd0);
        chk("t3_err_len", 32'(cmd_err), 32'h1);
        chk("t3_still_idle", 32'(cmd_ready), 32'h1);
        tick();
        chk("t3_err_clear", 32'(cmd_err), 32'h0);

        // maximum length with payload-stream gaps
        send_cmd(2'd2, 6'd63);
        for (int i = 0; i < 63; i++) begin
            push(8'(i));
            if (i % 10 == 9) tick();
        end
        chk("t4_hdr", 32'(data_out), 32'hFE);
        repeat (64) tick();
        chk("t4_parity", 32'(data_out), 32'hC1);
        chk("t4_parity_valid", 32'(pkt_valid), 32'h0);
        wait_idle("t4_idle");

        // asynchronous reset while the 2nd payload byte is on data_out
        send_cmd(2'd0, 6'd4);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(); tick();
        chk("t5_second", 32'(data_out), 32'h22);
        #1 resetn = 1'b0;
        #1;
        chk("t5_async_data", 32'(data_out), 32'h0);
        chk("t5_async_valid", 32'(pkt_valid), 32'h0);
        chk("t5_async_cnt", 32'(pkt_cnt), 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        send_cmd(2'd2, 6'd1);
        push(8'h5A);
        chk("t5_hdr", 32'(data_out), 32'h06);
        tick(); tick();
        chk("t5_parity", 32'(data_out), 32'h5C);
        wait_idle("t5_idle");

        // back-to-back commands with one gap cycle
        send_cmd(2'd1, 6'd2);
        push(8'h01); push(8'h02);
        chk("t6_hdr", 32'(data_out), 32'h09);
        repeat (3) tick();
        chk("t6_parity", 32'(data_out), 32'h0A);
        cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd1;
        tick();
        chk("t6_gap_ready", 32'(cmd_ready), 32'h0);
        chk("t6_gap_data", 32'(data_out), 32'h0);
        chk("t6_gap_done", 32'(pkt_done), 32'h1);
        tick();
        chk("t6_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        chk("t6_load", 32'(pl_ready), 32'h1);
        push(8'h77);
        chk("t6_hdr2", 32'(data_out), 32'h04);
        tick(); tick();
        chk("t6_parity2", 32'(data_out), 32'h73);
        wait_idle("t6_idle");
        chk("t6_cnt", 32'(pkt_cnt), 32'h3);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Host-side packet transmitter that drives the 1x3 router input port: header byte, payload bytes, then parity byte, honouring the router's busy back-pressure.
- Collects the full payload from a host byte stream into an internal buffer before transmission, so pkt_valid never drops mid-packet.
- Produces exactly the packet format the router FIFOs store: header {len[5:0], addr[1:0]}, where the length counts payload bytes only.

Parameters:
- Width, 8, data byte width (header layout requires 8)
- MaxLen, 63, payload buffer depth; equals the maximum 6-bit length field
- GapCycles, 1, idle cycles with pkt_valid=0 after parity before the next command is accepted (0 allowed)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at posedge
- cmd_addr  in  2  destination port 0..2
- cmd_len  in  6  payload length 1..63
- pl_valid  in  1  payload byte valid
- pl_data  in  Width  payload byte
- pl_ready  out  1  payload byte accepted when pl_valid&&pl_ready at posedge
- busy  in  1  router busy; byte on data_out consumed at posedge when busy=0 in HEADER/PAYLOAD/PARITY
- data_out  out  Width  byte to router
- pkt_valid  out  1  high for header and payload bytes, low for parity
- cmd_err  out  1  one-cycle pulse, rejected command
- pkt_done  out  1  one-cycle pulse after parity is consumed
- pkt_cnt  out  16  packets sent, wraps at 16'hFFFF->0

Behaviour:
- Reset is asynchronous on resetn only: state=IDLE; data_out=0, pkt_valid=0, cmd_err=0, pkt_done=0, pkt_cnt=0, indices and parity=0. Buffer contents are not reset.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- cmd_ready=1 only in IDLE. pl_ready=1 only in LOAD. All other outputs are registered.
- IDLE, command accepted:
  - If cmd_addr==2'b11 or cmd_len==0: cmd_err=1 for the next cycle; stay IDLE.
  - Otherwise: latch addr/len; idx=0; go to LOAD.
- LOAD:
  - Each accepted byte is written to buf[idx]; idx++.
  - On the edge accepting byte len-1: data_out<={len,addr}, pkt_valid<=1, parity<={len,addr}, idx<=0, go to HEADER.
  - pl_valid gaps stall LOAD indefinitely.
- HEADER/PAYLOAD, on an edge with busy=0 (byte consumed):
  - If bytes remain: data_out<=buf[idx], parity^=buf[idx], idx++, state PAYLOAD.
  - After the last payload byte is consumed: data_out<=parity (complete XOR of header and all payload), pkt_valid<=0, go to PARITY.
  - busy=1 holds data_out, pkt_valid, idx and parity unchanged, for any duration.
- PARITY, on an edge with busy=0:
  - data_out<=0; pkt_done=1 for the following cycle; pkt_cnt++.
  - Go to GAP with gap counter=GapCycles, or straight to IDLE if GapCycles==0.
- GAP: counts down one per cycle, then goes to IDLE. pkt_valid=0 and data_out=0 throughout.
- Latency, zero busy: header appears the cycle after the last payload byte is loaded; one byte per cycle thereafter; parity is on data_out len+1 cycles after the header.
- Reset asserted mid-operation: immediate return to the reset values; the partial packet is abandoned. The router side recovers via its own timeout/soft reset.
- cmd_valid/pl_valid outside IDLE/LOAD are ignored (no ready).

Decomposition:
- Shared package router_pkg:
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0)
  - ADDR_INVALID=2'b11
  - MAX_LEN=63
  - tx state enum
- One sub-module, router_tx_buf: MaxLen x Width single-write/single-read register array with synchronous write and combinational read, no reset.

Test Plan:
- addr=1, len=3, payload AA,BB,CC, busy=0 -> data_out sequence 0D,AA,BB,CC with pkt_valid=1, then D0 with pkt_valid=0; pkt_done pulse; pkt_cnt=1.
- Same packet with busy=1 for 3 cycles while BB is presented -> BB and pkt_valid=1 held 4 cycles; parity still D0.
- cmd_addr=3 len=5, then cmd_addr=0 len=0 -> two cmd_err pulses; pl_ready and pkt_valid stay 0; state IDLE.
- addr=2, len=63, payload 0..62 -> header FE; 63 payload bytes in order; parity = FE XOR (0^1^...^62); pl_valid gaps during LOAD cause no output.
- resetn low while the 2nd payload byte is on data_out -> data_out=0, pkt_valid=0, pkt_cnt=0 asynchronously; a new command is accepted after release.
- Two back-to-back valid commands, GapCycles=1 -> exactly one cycle of pkt_valid=0/data_out=0 after parity consumption before cmd_ready=1; second packet correct.
